// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the 32x32 register file: buffers results, drains
// one per cycle to the single write port and forwards pending values to decode.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  input  logic [AW-1:0]            q_ra1,
  input  logic [AW-1:0]            q_ra2,
  output logic                     fwd_hit1,
  output logic [DW-1:0]            fwd_data1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PW-1:0]            rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     store, pop;
  logic [PW-1:0]            fidx;

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = (count_q != CW'(DEPTH));
  assign rf_we    = !empty && drain_en;
  assign rf_wa    = empty ? '0 : addr_q[rp_q];
  assign rf_wd    = empty ? '0 : data_q[rp_q];

  // Register 0 completes the handshake but is never stored.
  assign store = in_valid && in_ready && (in_addr != '0);
  assign pop   = rf_we;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    if (pop) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PW'(1);
    end
    if (store) begin
      addr_d[wp_q]  = in_addr;
      data_d[wp_q]  = in_data;
      valid_d[wp_q] = 1'b1;
      wp_d          = wp_q + PW'(1);
    end
    count_d = count_q + CW'(store) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match wins; the head being written
  // this cycle is still searched since the register file has not updated yet.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    fidx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rp_q + PW'(k);
      if (valid_q[fidx] && (q_ra1 != '0) && (addr_q[fidx] == q_ra1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[fidx];
      end
      if (valid_q[fidx] && (q_ra2 != '0) && (addr_q[fidx] == q_ra2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[fidx];
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: accepted writes are queued as
// expectations and matched against every rf_we cycle by a negedge monitor.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          in_valid, in_ready, drain_en;
  logic [AW-1:0] in_addr, rf_wa, q_ra1, q_ra2;
  logic [DW-1:0] in_data, rf_wd, fwd_data1, fwd_data2;
  logic          rf_we, fwd_hit1, fwd_hit2, empty;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .q_ra1(q_ra1), .q_ra2(q_ra2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we) begin
      n_checks++;
      n_writes++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got wa=%0d wd=%h, required no write", rf_wa, rf_wd);
      end else begin
        mon_exp = sb.pop_front();
        if (rf_wa !== mon_exp.a || rf_wd !== mon_exp.d) begin
          n_fail++;
          $display("FAIL write_order: got wa=%0d wd=%h, required wa=%0d wd=%h",
                   rf_wa, rf_wd, mon_exp.a, mon_exp.d);
        end
      end
    end
  end

  // Drive one cycle of stimulus, record an expectation on acceptance, end at posedge+1.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic de);
    wr_t e;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = de;
    @(negedge clk);
    #1;
    if (in_valid && in_ready && in_addr != '0) begin
      e.a = a;
      e.d = d;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (rf_we !== 1'b0 || empty !== 1'b1 || count !== '0 || in_ready !== 1'b1 ||
        fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%b empty=%b count=%0d rdy=%b hit1=%b hit2=%b, required 0 1 0 1 0 0",
               rf_we, empty, count, in_ready, fwd_hit1, fwd_hit2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    n_checks++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_present: got we=%b wa=%0d wd=%h, required 1 5 deadbeef", rf_we, rf_wa, rf_wd);
    end
    step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (empty !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: got empty=%b we=%b, required 1 0", empty, rf_we);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), 32'h100 + DW'(i), 1'b0);
    n_checks++;
    if (count !== CW'(4) || in_ready !== 1'b0 || rf_we !== 1'b0 || rf_wa !== 5'd1) begin
      n_fail++;
      $display("FAIL full_state: got count=%0d rdy=%b we=%b wa=%0d, required 4 0 0 1",
               count, in_ready, rf_we, rf_wa);
    end
    // Offered while full with a concurrent pop: must still be refused.
    step(1'b1, 5'd9, 32'h999, 1'b1);
    n_checks++;
    if (count !== CW'(3) || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject: got count=%0d rdy=%b, required 3 1", count, in_ready);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (empty !== 1'b1 || count !== '0) begin
      n_fail++;
      $display("FAIL full_drained: got empty=%b count=%0d, required 1 0", empty, count);
    end
  endtask

  task automatic test_forward();
    in_valid = 1'b1;
    in_addr  = 5'd7;
    in_data  = 32'h11;
    drain_en = 1'b0;
    q_ra1    = 5'd7;
    #1;
    n_checks++;
    if (fwd_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_no_bypass: got hit1=%b, required 0", fwd_hit1);
    end
    step(1'b1, 5'd7, 32'h11, 1'b0);
    step(1'b1, 5'd7, 32'h22, 1'b0);
    n_checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_youngest: got hit1=%b data1=%h, required 1 22", fwd_hit1, fwd_data1);
    end
    step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
      n_fail++;
      $display("FAIL fwd_after_pop1: got hit1=%b data1=%h, required 1 22", fwd_hit1, fwd_data1);
    end
    step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (fwd_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_after_pop2: got hit1=%b, required 0", fwd_hit1);
    end
    q_ra1 = '0;
  endtask

  task automatic test_zero_reg();
    in_valid = 1'b1;
    in_addr  = '0;
    in_data  = 32'hFFFF;
    drain_en = 1'b1;
    q_ra2    = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_ready: got rdy=%b, required 1", in_ready);
    end
    step(1'b1, '0, 32'hFFFF, 1'b1);
    n_checks++;
    if (count !== '0 || empty !== 1'b1 || fwd_hit2 !== 1'b0 || fwd_data2 !== '0) begin
      n_fail++;
      $display("FAIL zero_dropped: got count=%0d empty=%b hit2=%b data2=%h, required 0 1 0 0",
               count, empty, fwd_hit2, fwd_data2);
    end
    step(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = n_writes;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, AW'(1 + i), $urandom, 1'b1);
      n_checks++;
      if (count !== CW'(1)) begin
        n_fail++;
        $display("FAIL stream_count[%0d]: got %0d, required 1", i, count);
      end
    end
    step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (n_writes - w0 !== 20 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_writes: got %0d writes empty=%b, required 20 1", n_writes - w0, empty);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    step(1'b1, 5'd10, 32'hA0A0, 1'b0);
    step(1'b1, 5'd11, 32'hB1B1, 1'b0);
    step(1'b1, 5'd12, 32'hC2C2, 1'b0);
    in_valid = 1'b0;
    drain_en = 1'b1;
    q_ra1    = 5'd11;
    #1;
    n_checks++;
    if (rf_we !== 1'b1 || count !== CW'(3) || fwd_hit1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got we=%b count=%0d hit1=%b, required 1 3 1", rf_we, count, fwd_hit1);
    end
    #1;
    rst = 1'b1;
    sb.delete();
    w0 = n_writes;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || count !== '0 || fwd_hit1 !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: got we=%b count=%0d hit1=%b empty=%b, required 0 0 0 1",
               rf_we, count, fwd_hit1, empty);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1);
    n_checks++;
    if (n_writes !== w0 || empty !== 1'b1 || fwd_hit1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_stale: got %0d writes empty=%b hit1=%b, required 0 1 0",
               n_writes - w0, empty, fwd_hit1);
    end
    q_ra1 = '0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    drain_en = 1'b0;
    q_ra1    = '0;
    q_ra2    = '0;
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_zero_reg();
    test_back_to_back();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding writes, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
